dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port data memory (32-bit words,

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (IDLE -> ACC -> RSP).
// Optional macro DMEM_ARB_RR_EN selects round-robin contention; default is port0 priority.
module dmem_arbiter #(
  parameter int DEPTH = 100,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          done0,
  output logic [DW-1:0] rd0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          done1,
  output logic [DW-1:0] rd1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  state_t        state_q;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q;
  logic          done0_q;
  logic          done1_q;
  logic [DW-1:0] rd0_q;
  logic [DW-1:0] rd1_q;
  logic          err_q;

  logic          win_d;
  logic          inRange;
  logic [DW-1:0] rdata_d;

`ifdef DMEM_ARB_RR_EN
  logic          last_q;

  // On contention the port that did not win last time is granted.
  always_comb begin
    win_d = req1 & (~req0 | ~last_q);
  end
`else
  always_comb begin
    win_d = req1 & ~req0;
  end
`endif

  always_comb begin
    inRange = (addr_q < AW'(DEPTH));
    rdata_d = inRange ? mem_rd : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            win_q   <= win_d;
            we_q    <= win_d ? we1 : we0;
            addr_q  <= win_d ? addr1 : addr0;
            wd_q    <= win_d ? wd1 : wd0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= win_d;
`endif
            state_q <= ACC;
          end
        end
        ACC: begin
          // Response flags are registered here so they are visible during RSP.
          done0_q <= ~win_q;
          done1_q <= win_q;
          err_q   <= ~inRange;
          if (!we_q) begin
            if (win_q) rd1_q <= rdata_d;
            else       rd0_q <= rdata_d;
          end
          state_q <= RSP;
        end
        RSP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write strobe is gated by rst so a write landing on a reset edge is dropped.
  assign mem_we = (state_q == ACC) & we_q & inRange & ~rst;
  assign mem_a  = addr_q;
  assign mem_wd = wd_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rd0    = rd0_q;
  assign rd1    = rd1_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 100-word memory on the mem_* side.
module tb_dmem_arbiter;

  localparam int DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic        done0, done1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we, err, busy;

  typedef struct {
    logic        port;
    logic        isRead;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] shadow[DEPTH];
  logic [31:0] mem[DEPTH];
  logic        memReady = 1'b0;
  logic [31:0] expRd0 = '0;
  logic [31:0] expRd1 = '0;
  int          checks = 0;
  int          errors = 0;
  int          weCount = 0;
  int          expWeCount = 0;
  int          lat;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0), .done0(done0), .rd0(rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .done1(done1), .rd1(rd1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0193);
  endfunction

  // Memory model: preloaded on the first edge, out-of-range reads return junk.
  assign mem_rd = (mem_a < DEPTH) ? mem[mem_a[6:0]] : 32'hBADC_0FFE;

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
      memReady <= 1'b1;
    end else if (mem_we && (mem_a < DEPTH)) begin
      mem[mem_a[6:0]] <= mem_wd;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wd1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wd0 = wd;
    end
  endtask

  // Expected result of one granted transaction, queued in grant order.
  task automatic expectTxn(input logic port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.port   = port;
    e.isRead = ~we;
    e.err    = (addr >= DEPTH);
    e.rd     = (!we && addr < DEPTH) ? shadow[addr[6:0]] : 32'h0;
    if (we && addr < DEPTH) begin
      shadow[addr[6:0]] = wd;
      expWeCount++;
    end
    expQ.push_back(e);
  endtask

  task automatic waitDone(input int n, input bit drop, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done0) begin seen++; if (drop) req0 = 1'b0; end
      if (done1) begin seen++; if (drop) req1 = 1'b0; end
    end
    if (seen < n) checkOutput("doneTimeout", 32'(seen), 32'(n));
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rdv;
    if (mem_we) begin
      weCount++;
      checkOutput("weAddrRange", 32'(mem_a >= DEPTH), 32'h0);
    end
    if (done0 || done1) begin
      checkOutput("doneOneHot", 32'(done0 & done1), 32'h0);
      if (expQ.size() == 0) begin
        checkOutput("doneExpected", 32'(expQ.size()), 32'h1);
      end else begin
        e   = expQ.pop_front();
        rdv = e.port ? rd1 : rd0;
        checkOutput("donePort", 32'(done1), 32'(e.port));
        if (e.isRead) begin
          checkOutput("readData", rdv, e.rd);
          if (e.port) expRd1 = e.rd;
          else        expRd0 = e.rd;
        end else begin
          checkOutput("rdHeld", rdv, e.port ? expRd1 : expRd0);
        end
        checkOutput("errFlag", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = pattern(i);

    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstMemWe", 32'(mem_we), 32'h0);
    checkOutput("rstDone0", 32'(done0), 32'h0);
    checkOutput("rstDone1", 32'(done1), 32'h0);
    checkOutput("rstRd0", rd0, 32'h0);
    checkOutput("rstRd1", rd1, 32'h0);
    checkOutput("rstErr", 32'(err), 32'h0);
    rst = 1'b0;

    // Single-port write then read back, plus a cross-port write/read
    applyStimulus(0, 1, 5, 32'hDEAD_BEEF); expectTxn(0, 1, 5, 32'hDEAD_BEEF);
    waitDone(1, 1, lat); checkOutput("latWrite", 32'(lat), 32'd2);
    @(negedge clk);
    applyStimulus(0, 0, 5, 0); expectTxn(0, 0, 5, 0);
    waitDone(1, 1, lat); checkOutput("latRead", 32'(lat), 32'd2);
    @(negedge clk);
    applyStimulus(1, 1, 42, 32'hCAFE_F00D); expectTxn(1, 1, 42, 32'hCAFE_F00D);
    waitDone(1, 1, lat);
    @(negedge clk);
    applyStimulus(0, 0, 42, 0); expectTxn(0, 0, 42, 0);
    waitDone(1, 1, lat);
    @(negedge clk);

    // Simultaneous reads; last winner so far is port0
    applyStimulus(0, 0, 5, 0); applyStimulus(1, 0, 42, 0);
`ifdef DMEM_ARB_RR_EN
    expectTxn(1, 0, 42, 0); expectTxn(0, 0, 5, 0);
`else
    expectTxn(0, 0, 5, 0); expectTxn(1, 0, 42, 0);
`endif
    waitDone(2, 1, lat); checkOutput("latContend", 32'(lat), 32'd5);
    @(negedge clk);

    // Both requests held high across four grants
    applyStimulus(0, 0, 10, 0); applyStimulus(1, 0, 11, 0);
`ifdef DMEM_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      expectTxn(1, 0, 11, 0); expectTxn(0, 0, 10, 0);
    end
`else
    for (int k = 0; k < 4; k++) expectTxn(0, 0, 10, 0);
`endif
    waitDone(4, 0, lat); checkOutput("latHeld", 32'(lat), 32'd11);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Out-of-range write and read on port1
    applyStimulus(1, 1, 100, 32'h1); expectTxn(1, 1, 100, 32'h1);
    waitDone(1, 1, lat);
    @(negedge clk);
    applyStimulus(1, 0, 100, 0); expectTxn(1, 0, 100, 0);
    waitDone(1, 1, lat);
    @(negedge clk);

    // Reset arriving during the ACC cycle of a write
    applyStimulus(0, 1, 7, 32'h1111_2222); expectTxn(0, 1, 7, 32'h1111_2222);
    waitDone(1, 1, lat);
    @(negedge clk);
    applyStimulus(0, 1, 7, 32'h55);
    @(negedge clk);
    checkOutput("accBusy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstAccWe", 32'(mem_we), 32'h0);
    @(negedge clk);
    req0 = 1'b0;
    checkOutput("rstDropBusy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expRd0 = '0; expRd1 = '0;
    checkOutput("rstClrRd0", rd0, 32'h0);
    checkOutput("rstClrDone0", 32'(done0), 32'h0);

    // After reset port0 is preferred again and address 7 kept its old value
    applyStimulus(0, 0, 7, 0); applyStimulus(1, 0, 5, 0);
    expectTxn(0, 0, 7, 0); expectTxn(1, 0, 5, 0);
    waitDone(2, 1, lat);
    repeat (3) @(negedge clk);

    checkOutput("memWeCount", 32'(weCount), 32'(expWeCount));
    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
